// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//
// This interface bundles the arbiter's request, response and RAM signals.
//
// Modports:
//   slave  - the arbiter. It receives the fetch and data requests and the RAM read data. It drives
//            the grants, the responses, the RAM control and stall.
//   master - the requesting pipeline together with the RAM model.
//
// Signals:
//   i_req/i_addr                fetch request and word address
//   i_gnt, i_rvalid, i_rdata    fetch grant, registered read valid, read data
//   d_req/d_we/d_addr/d_wdata   load/store request
//   d_gnt, d_rvalid, d_rdata    data grant, registered load valid, load data
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  single-port synchronous RAM
//   stall                       a pending request was not granted this cycle
interface mem_port_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 16
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              stall;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, stall
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// The ASIP has one single-port synchronous RAM. This block shares that RAM between instruction
// fetch and load/store. It grants at most one access per cycle. Data accesses win by default.
// A saturating wait counter counts the consecutive cycles in which fetch was denied. When that
// count reaches STARVE_LIMIT, fetch wins the next contended cycle. The RAM returns read data one
// cycle after the access. A small response-owner FSM records which port issued the read, so the
// matching rvalid rises in that next cycle.
//
// Parameters:
//   DATA_W        read/write data width
//   ADDR_W        word address width
//   STARVE_LIMIT  denied fetch cycles before fetch takes priority (1..15)
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high. While it is high, both grants are forced to 0.
//   bus    mem_port_arbiter_if.slave: fetch port, data port, RAM port, stall
module mem_port_arbiter #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    RespNone,
    RespFetch,
    RespLoad
  } resp_e;

  resp_e       resp_state;
  logic [3:0]  wait_cnt;
  logic        fetch_gnt;
  logic        data_gnt;
  logic        fetch_prio;

  // Fetch has waited long enough; it wins the next contended cycle.
  assign fetch_prio = (wait_cnt == Limit);

  // ---------------------------------------------------------------------------
  // Grant select. This is combinational, so a request is granted in the same cycle it is raised.
  // ---------------------------------------------------------------------------
  always_comb begin
    fetch_gnt = 1'b0;
    data_gnt  = 1'b0;
    if (!reset) begin
      if (bus.i_req && bus.d_req) begin
        if (fetch_prio) begin
          fetch_gnt = 1'b1;
        end else begin
          data_gnt = 1'b1;
        end
      end else begin
        fetch_gnt = bus.i_req;
        data_gnt  = bus.d_req;
      end
    end
  end

  assign bus.i_gnt = fetch_gnt;
  assign bus.d_gnt = data_gnt;

  // ---------------------------------------------------------------------------
  // RAM port mux. Write data is zero unless a data access owns the port.
  // ---------------------------------------------------------------------------
  assign bus.mem_en    = fetch_gnt | data_gnt;
  assign bus.mem_we    = data_gnt & bus.d_we;
  assign bus.mem_addr  = data_gnt ? bus.d_addr : bus.i_addr;
  assign bus.mem_wdata = data_gnt ? bus.d_wdata : '0;

  assign bus.stall = (bus.i_req & ~fetch_gnt) | (bus.d_req & ~data_gnt);

  // ---------------------------------------------------------------------------
  // Starvation counter. It counts consecutive denied fetch cycles and saturates at the limit.
  // It clears when fetch is granted. It also clears when the fetch request goes away, including
  // a request that is withdrawn before it is granted.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= 4'd0;
    end else if (fetch_gnt || !bus.i_req) begin
      wait_cnt <= 4'd0;
    end else if (wait_cnt != Limit) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Response-owner FSM. The state names the port whose read was issued last cycle. Because the
  // state is re-decided every cycle, back-to-back reads from either port are allowed. Stores do
  // not produce a response.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_state <= RespNone;
    end else if (fetch_gnt) begin
      resp_state <= RespFetch;
    end else if (data_gnt && !bus.d_we) begin
      resp_state <= RespLoad;
    end else begin
      resp_state <= RespNone;
    end
  end

  // Decoding the state register alone keeps both rvalid outputs glitch-free.
  assign bus.i_rvalid = (resp_state == RespFetch);
  assign bus.d_rvalid = (resp_state == RespLoad);

  // Both response ports carry the raw RAM data. Consumers qualify it with their own rvalid.
  assign bus.i_rdata = bus.mem_rdata;
  assign bus.d_rdata = bus.mem_rdata;

  // Only one owner may ever drive the single RAM port.
  a_one_grant : assert property (@(posedge clk) !(fetch_gnt && data_gnt));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. It drives directed request vectors and models the RAM.
//
// A reference model checks every cycle. The model holds:
//   - a denied-fetch streak;
//   - the expected owner of the pending response, and its data;
//   - a shadow image of the memory.
//
// Literal expectations at the notable points of each scenario pin the model itself.
module tb_mem_port_arbiter;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 16;
  localparam int unsigned LIM = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  mem_port_arbiter #(
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // RAM model: synchronous single port. It is preloaded while ram_init is high.
  logic          ram_init = 1'b1;
  logic [DW-1:0] ram [0:255];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= (i == 4) ? 32'h0000A5A5 : 32'h0;
      bus.mem_rdata <= '0;
    end else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
      else            bus.mem_rdata <= ram[bus.mem_addr[7:0]];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model and per-cycle comparison. This runs on the negedge. Inputs change only just
  // after the posedge, so the values seen here are the ones the next posedge will sample.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] shadow [int];
  int            streak     = 0;  // consecutive denied fetch cycles
  int            pend_owner = 0;  // 0 none, 1 fetch, 2 load
  logic [DW-1:0] pend_data  = '0;

  function automatic logic [DW-1:0] shadow_rd(input logic [AW-1:0] a);
    if (shadow.exists(int'(a))) return shadow[int'(a)];
    return '0;
  endfunction

  initial begin
    logic ei, ed, both;
    shadow[4] = 32'h0000A5A5;
    forever begin
      @(negedge clk);
      both = bus.i_req && bus.d_req;
      if (reset) begin
        ei = 1'b0;
        ed = 1'b0;
      end else if (both) begin
        ei = (streak >= int'(LIM));
        ed = !ei;
      end else begin
        ei = bus.i_req;
        ed = bus.d_req;
      end

      chk("i_gnt", 64'(bus.i_gnt), 64'(ei));
      chk("d_gnt", 64'(bus.d_gnt), 64'(ed));
      chk("mem_en", 64'(bus.mem_en), 64'(ei | ed));
      chk("mem_we", 64'(bus.mem_we), 64'(ed & bus.d_we));
      chk("stall", 64'(bus.stall), 64'((bus.i_req & ~ei) | (bus.d_req & ~ed)));
      chk("mem_wdata", 64'(bus.mem_wdata), ed ? 64'(bus.d_wdata) : 64'(0));
      if (ei) chk("mem_addr_i", 64'(bus.mem_addr), 64'(bus.i_addr));
      if (ed) chk("mem_addr_d", 64'(bus.mem_addr), 64'(bus.d_addr));
      chk("i_rvalid", 64'(bus.i_rvalid), 64'(pend_owner == 1));
      chk("d_rvalid", 64'(bus.d_rvalid), 64'(pend_owner == 2));
      if (pend_owner == 1) chk("i_rdata", 64'(bus.i_rdata), 64'(pend_data));
      if (pend_owner == 2) chk("d_rdata", 64'(bus.d_rdata), 64'(pend_data));

      // Advance the model to the state after the coming posedge.
      if (reset) begin
        streak     = 0;
        pend_owner = 0;
      end else begin
        if (bus.i_req && !ei) streak = (streak < int'(LIM)) ? streak + 1 : streak;
        else                  streak = 0;
        if (ei) begin
          pend_owner = 1;
          pend_data  = shadow_rd(bus.i_addr);
        end else if (ed && !bus.d_we) begin
          pend_owner = 2;
          pend_data  = shadow_rd(bus.d_addr);
        end else begin
          pend_owner = 0;
        end
        if (ed && bus.d_we) shadow[int'(bus.d_addr)] = bus.d_wdata;
      end
    end
  end

  // Drives one cycle of inputs just after the posedge. It returns at the negedge of that cycle,
  // so the outputs can be inspected while they are stable.
  task automatic step(input logic rst, input logic ir, input logic [AW-1:0] ia,
                      input logic dr, input logic dwe, input logic [AW-1:0] da,
                      input logic [DW-1:0] dwd);
    @(posedge clk);
    #1;
    reset       = rst;
    bus.i_req   = ir;
    bus.i_addr  = ia;
    bus.d_req   = dr;
    bus.d_we    = dwe;
    bus.d_addr  = da;
    bus.d_wdata = dwd;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
  endtask

  initial begin
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

    // Reset: a fetch request is pending, but it must not be granted.
    step(1'b1, 1'b1, 16'h4, 1'b0, 1'b0, 16'h0, 32'h0);
    ram_init = 1'b0;
    step(1'b1, 1'b1, 16'h4, 1'b0, 1'b0, 16'h0, 32'h0);
    chk("rst_i_gnt", 64'(bus.i_gnt), 64'(0));
    chk("rst_mem_en", 64'(bus.mem_en), 64'(0));
    chk("rst_stall", 64'(bus.stall), 64'(1));
    chk("rst_i_rvalid", 64'(bus.i_rvalid), 64'(0));

    // Fetch only.
    step(1'b0, 1'b1, 16'h4, 1'b0, 1'b0, 16'h0, 32'h0);
    chk("f_i_gnt", 64'(bus.i_gnt), 64'(1));
    chk("f_stall", 64'(bus.stall), 64'(0));
    idle();
    chk("f_i_rvalid", 64'(bus.i_rvalid), 64'(1));
    chk("f_i_rdata", 64'(bus.i_rdata), 64'h0000A5A5);

    // Store, then a load of the same word.
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h10, 32'hDEADBEEF);
    chk("st_mem_we", 64'(bus.mem_we), 64'(1));
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h10, 32'h0);
    chk("st_no_rvalid", 64'(bus.d_rvalid), 64'(0));
    idle();
    chk("ld_d_rvalid", 64'(bus.d_rvalid), 64'(1));
    chk("ld_d_rdata", 64'(bus.d_rdata), 64'hDEADBEEF);

    // Contention. Data wins three times, then fetch wins, then the count restarts.
    for (int k = 1; k <= 5; k++) begin
      step(1'b0, 1'b1, 16'h8, 1'b1, 1'b0, 16'h10, 32'h0);
      if (k <= 3) begin
        chk("cont_d_gnt", 64'(bus.d_gnt), 64'(1));
        chk("cont_stall", 64'(bus.stall), 64'(1));
      end else if (k == 4) begin
        chk("cont_i_gnt4", 64'(bus.i_gnt), 64'(1));
      end else begin
        chk("cont_d_gnt5", 64'(bus.d_gnt), 64'(1));
      end
    end
    idle();
    idle();

    // Alternating owners: fetch, then load, then fetch.
    step(1'b0, 1'b1, 16'h4, 1'b0, 1'b0, 16'h0, 32'h0);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h10, 32'h0);
    chk("alt_i_rv", 64'({bus.i_rvalid, bus.d_rvalid}), 64'(2'b10));
    step(1'b0, 1'b1, 16'h4, 1'b0, 1'b0, 16'h0, 32'h0);
    chk("alt_d_rv", 64'({bus.i_rvalid, bus.d_rvalid}), 64'(2'b01));
    chk("alt_d_rdata", 64'(bus.d_rdata), 64'hDEADBEEF);
    idle();
    chk("alt_i_rv2", 64'({bus.i_rvalid, bus.d_rvalid}), 64'(2'b10));
    chk("alt_i_rdata", 64'(bus.i_rdata), 64'h0000A5A5);

    // Reset arrives while a load response is pending.
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h10, 32'h0);
    step(1'b1, 1'b1, 16'h4, 1'b1, 1'b0, 16'h10, 32'h0);
    chk("rm_d_rvalid1", 64'(bus.d_rvalid), 64'(1));
    chk("rm_no_gnt", 64'({bus.i_gnt, bus.d_gnt}), 64'(0));
    step(1'b1, 1'b1, 16'h4, 1'b1, 1'b0, 16'h10, 32'h0);
    chk("rm_d_rvalid2", 64'(bus.d_rvalid), 64'(0));
    idle();

    // A fetch is withdrawn after two denied cycles. The streak must restart from zero.
    step(1'b0, 1'b1, 16'h4, 1'b1, 1'b1, 16'h30, 32'h12345678);
    step(1'b0, 1'b1, 16'h4, 1'b1, 1'b0, 16'h20, 32'h0);
    step(1'b0, 1'b0, 16'h4, 1'b1, 1'b0, 16'h20, 32'h0);
    chk("wd_no_fetch", 64'(bus.mem_addr), 64'h20);
    chk("wd_stall", 64'(bus.stall), 64'(0));
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 1'b1, 16'h4, 1'b1, 1'b0, 16'h30, 32'h0);
      if (k == 2) chk("wd_d_gnt2", 64'(bus.d_gnt), 64'(1));
      if (k == 4) chk("wd_i_gnt4", 64'(bus.i_gnt), 64'(1));
    end
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
